// File: rtl/tx_frame_packetizer.sv
// tx_frame_packetizer: buffers pixel bytes in a small FIFO and streams a
// framed packet (sync, 16-bit command, payload, 8-bit checksum) to a UART
// transmitter through a one-send-per-ready-pulse handshake.
module tx_frame_packetizer #(
  parameter int          PIXEL_WIDTH   = 8,
  parameter int          COMMAND_WIDTH = 16,
  parameter int          FRAME_LENGTH  = 76800,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [COMMAND_WIDTH-1:0] command,
  input  logic [PIXEL_WIDTH-1:0]   pixel_data,
  input  logic                     pixel_is_new,
  output logic                     pixel_ready,
  output logic [7:0]               UART_data,
  output logic                     UART_is_new,
  input  logic                     UART_ready,
  output logic                     busy,
  output logic                     overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(FRAME_LENGTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CMD_HI,
    CMD_LO,
    PAYLOAD,
    CHECKSUM
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [COMMAND_WIDTH-1:0] r_cmd;
  logic [PIXEL_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [FCNT_W-1:0]        r_count;
  logic [7:0]               r_checksum;
  logic [CNT_W-1:0]         r_payload_cnt;
  logic                     r_armed;
  logic                     r_overflow;
  logic [7:0]               r_uart_data;
  logic                     r_uart_is_new;

  logic                     w_start;
  logic                     w_pixel_ready;
  logic                     w_wr;
  logic                     w_fifo_empty;
  logic                     w_can_send;
  logic                     w_send;
  logic                     w_pop;
  logic [7:0]               w_send_data;
  logic [7:0]               w_rd_byte;
  logic [15:0]              w_cmd16;

  assign w_start       = frame_start && (r_state == IDLE);
  assign w_fifo_empty  = (r_count == '0);
  assign w_pixel_ready = (r_count < FCNT_W'(FIFO_DEPTH)) && (r_state != IDLE);
  assign w_wr          = pixel_is_new && w_pixel_ready;
  assign w_can_send    = UART_ready && r_armed;
  assign w_rd_byte     = 8'(r_mem[r_rd_ptr]);
  assign w_cmd16       = 16'(r_cmd);

  assign pixel_ready = w_pixel_ready;
  assign UART_data   = r_uart_data;
  assign UART_is_new = r_uart_is_new;
  assign busy        = (r_state != IDLE);
  assign overflow    = r_overflow;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and send decision; each non-idle state emits one byte
  always_comb begin
    w_next_state = r_state;
    w_send       = 1'b0;
    w_pop        = 1'b0;
    w_send_data  = r_uart_data;
    case (r_state)
      IDLE: begin
        if (frame_start) w_next_state = SYNC;
      end
      SYNC: begin
        if (w_can_send) begin
          w_send       = 1'b1;
          w_send_data  = SYNC_BYTE;
          w_next_state = CMD_HI;
        end
      end
      CMD_HI: begin
        if (w_can_send) begin
          w_send       = 1'b1;
          w_send_data  = w_cmd16[15:8];
          w_next_state = CMD_LO;
        end
      end
      CMD_LO: begin
        if (w_can_send) begin
          w_send       = 1'b1;
          w_send_data  = w_cmd16[7:0];
          w_next_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_can_send && !w_fifo_empty) begin
          w_send      = 1'b1;
          w_pop       = 1'b1;
          w_send_data = w_rd_byte;
          if (r_payload_cnt == CNT_W'(FRAME_LENGTH - 1)) w_next_state = CHECKSUM;
        end
      end
      CHECKSUM: begin
        if (w_can_send) begin
          w_send       = 1'b1;
          w_send_data  = r_checksum;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FIFO storage; writes can only be accepted outside IDLE
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= pixel_data;
  end

  // Datapath: UART output register, handshake arming, FIFO pointers, checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_uart_data   <= '0;
      r_uart_is_new <= 1'b0;
      r_armed       <= 1'b1;
      r_overflow    <= 1'b0;
      r_cmd         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_checksum    <= '0;
      r_payload_cnt <= '0;
    end else begin
      r_uart_is_new <= w_send;
      if (w_send) r_uart_data <= w_send_data;

      if (w_send)           r_armed <= 1'b0;
      else if (!UART_ready) r_armed <= 1'b1;

      if (pixel_is_new && !w_pixel_ready && (r_state != IDLE)) r_overflow <= 1'b1;

      if (w_start) begin
        r_cmd         <= command;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_count       <= '0;
        r_checksum    <= '0;
        r_payload_cnt <= '0;
      end else if (w_send && (r_state == CHECKSUM)) begin
        // Frame complete: anything still buffered belongs to no frame.
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) begin
          r_rd_ptr      <= r_rd_ptr + 1'b1;
          r_checksum    <= r_checksum + w_rd_byte;
          r_payload_cnt <= r_payload_cnt + 1'b1;
        end
        case ({w_wr, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: doc/tx_frame_packetizer.md
TX_FRAME_PACKETIZER -- requirements
Module: tx_frame_packetizer

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: payload byte width.
REQ-002 Parameter COMMAND_WIDTH, default 16: latched command width, sent as two header bytes.
REQ-003 Parameter FRAME_LENGTH, default 76800: payload bytes per frame (320x240).
REQ-004 Parameter FIFO_DEPTH, default 16: input buffer depth in bytes, a power of two.
REQ-005 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-006 Port list SHALL be:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- frame_start  input  1  pulse that opens a frame.
- command  input  COMMAND_WIDTH  command echoed in the header.
- pixel_data  input  PIXEL_WIDTH  filtered pixel byte.
- pixel_is_new  input  1  write strobe for pixel_data.
- pixel_ready  output  1  FIFO has space.
- UART_data  output  8  byte to the UART transmitter.
- UART_is_new  output  1  one-cycle send strobe.
- UART_ready  input  1  transmitter idle.
- busy  output  1  frame in progress.
- overflow  output  1  sticky dropped-write flag.
REQ-007 Clocking SHALL be one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-008 States SHALL be IDLE, SYNC, CMD_HI, CMD_LO, PAYLOAD and CHECKSUM.
REQ-009 Frame wire format SHALL be, in order:
- SYNC_BYTE
- command[15:8]
- command[7:0]
- FRAME_LENGTH payload bytes in FIFO order
- checksum = 8-bit sum, mod 256, of all payload bytes.
REQ-010 On frame_start in IDLE, the block SHALL:
- latch command;
- clear the checksum, payload counter and FIFO;
- enter SYNC next cycle.
REQ-011 frame_start outside IDLE SHALL be ignored; the latched command SHALL NOT change.
REQ-012 busy SHALL equal (state != IDLE).
REQ-013 pixel_ready SHALL be combinational: 1 when FIFO count < FIFO_DEPTH and state != IDLE.
REQ-014 A write SHALL be accepted iff pixel_is_new=1 and pixel_ready=1 in the same cycle; a read in that cycle does not free space for it.
REQ-015 pixel_is_new=1 with pixel_ready=0 outside IDLE SHALL drop the byte and set overflow; overflow SHALL stay set until rst.
REQ-016 pixel_is_new in IDLE SHALL be ignored and SHALL NOT set overflow.
REQ-017 The send handshake SHALL be:
- a send is issued only when UART_ready=1 and the block is armed;
- issuing a send disarms the block;
- the block re-arms on the first cycle UART_ready is sampled 0.
REQ-018 UART_data and UART_is_new SHALL be registered: a send decided in cycle n appears as UART_is_new=1 with valid UART_data in cycle n+1.
REQ-019 UART_is_new SHALL be high for exactly one cycle per byte; UART_data SHALL hold its value until the next send.
REQ-020 In PAYLOAD, a send additionally requires a non-empty FIFO; the send pops the FIFO and adds the byte to the checksum.
REQ-021 The payload counter SHALL be ceil(log2(FRAME_LENGTH+1)) bits wide; PAYLOAD goes to CHECKSUM when the FRAME_LENGTH-th byte is sent.
REQ-022 After the checksum byte is sent, the block SHALL return to IDLE; any residual FIFO contents are discarded.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range from 0 to FIFO_DEPTH.
REQ-024 Latency: frame_start in cycle t with UART_ready=1 SHALL give the first UART_is_new (SYNC_BYTE) in cycle t+2.

Reset
REQ-025 On rst, the following SHALL be 0: UART_data, UART_is_new, busy, overflow, FIFO count, pointers, checksum, payload counter; pixel_ready SHALL then read 0.
REQ-026 On rst, state SHALL be IDLE and the block armed.
REQ-027 rst mid-frame SHALL abort the frame with no further UART_is_new; the next frame starts cleanly from frame_start.

Verification (FRAME_LENGTH=4, FIFO_DEPTH=4, command=16'h1234)
REQ-028 Basic frame: frame_start, then pixels 01,02,03,04, with UART_ready toggling 1 -> 0 -> 1 after each strobe -> bytes A5,12,34,01,02,03,04,0A; busy drops after 0A.
REQ-029 Overflow: frame_start, UART_ready held 0, five pixel writes -> pixel_ready=0 after the fourth; fifth dropped; overflow=1. Then release UART_ready -> payload 4 bytes, then checksum.
REQ-030 Handshake: UART_ready held 1 and never dropping -> exactly one UART_is_new (A5) issued; no further strobes until ready toggles low.
REQ-031 Wrap and checksum: payload FF,FF,FF,FF fed across pointer wrap -> checksum FC; data order preserved.
REQ-032 Robustness:
- frame_start during PAYLOAD -> ignored, header unchanged.
- rst during CMD_LO -> all outputs 0 next cycle; new frame with command=16'hABCD sends A5,AB,CD,...
- pixel writes in IDLE -> no overflow.
